// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic-unit self-test sweep: FSM encoding,
// output bit positions and the expected truth table indexed by {Inp_2, Inp_1}.
package logic_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } sweep_state_e;

  localparam int OUT_W    = 5;
  localparam int OUT_NOT  = 0;
  localparam int OUT_AND  = 1;
  localparam int OUT_OR   = 2;
  localparam int OUT_NAND = 3;
  localparam int OUT_XOR  = 4;

  function automatic logic [OUT_W-1:0] truth_row(input logic [1:0] vec);
    logic [OUT_W-1:0] row;
    row           = {OUT_W{1'b0}};
    row[OUT_NOT]  = ~vec[0];
    row[OUT_AND]  = vec[0] & vec[1];
    row[OUT_OR]   = vec[0] | vec[1];
    row[OUT_NAND] = ~(vec[0] & vec[1]);
    row[OUT_XOR]  = vec[0] ^ vec[1];
    return row;
  endfunction

  // 00 -> 01001, 01 -> 11100, 10 -> 11101, 11 -> 00110
  localparam logic [OUT_W-1:0] EXP_TABLE [4] = '{
    truth_row(2'd0), truth_row(2'd1), truth_row(2'd2), truth_row(2'd3)
  };

endpackage

// File: rtl/logic_unit_sweep_ctrl_hold_timer.sv
// Loadable down-counter that sets how long each sweep vector is held.
// It stops at zero, and zero is reported combinationally from the count.
module sweep_hold_timer #(
  parameter int TMR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [TMR_W-1:0] load_val,
  output logic             zero
);

  logic [TMR_W-1:0] count_q;
  logic [TMR_W-1:0] count_d;

  assign zero = (count_q == {TMR_W{1'b0}});

  // next count: load wins, otherwise count down to zero and stop there
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && !zero) begin
      count_d = count_q - {{(TMR_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {TMR_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/logic_unit_sweep_ctrl.sv
// Self-test sequencer: steps the logic unit through all four input vectors,
// checks the five outputs against the truth table and records the results.
module logic_unit_sweep_ctrl
  import logic_unit_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int TMR_W       = 8,
  parameter int ERR_W       = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  output logic             Inp_1,
  output logic             Inp_2,
  input  logic [OUT_W-1:0] Outp,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [ERR_W-1:0] Err_Cnt,
  output logic [1:0]       Fail_Vec,
  output logic [OUT_W-1:0] Fail_Mask
);

  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);

  sweep_state_e     state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [1:0]       inp_q, inp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [1:0]       fail_vec_q, fail_vec_d;
  logic [OUT_W-1:0] fail_mask_q, fail_mask_d;
  logic [OUT_W-1:0] diff_s;
  logic             tmr_load_s, tmr_en_s, tmr_zero_s;

  sweep_hold_timer #(.TMR_W(TMR_W)) u_hold_timer (
    .clk      (Clk),
    .rst      (Rst),
    .load     (tmr_load_s),
    .en       (tmr_en_s),
    .load_val (HOLD_LOAD),
    .zero     (tmr_zero_s)
  );

  // sweep FSM next-state, comparator and result update
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    inp_d       = inp_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    fail_vec_d  = fail_vec_q;
    fail_mask_d = fail_mask_q;
    tmr_load_s  = 1'b0;
    tmr_en_s    = 1'b0;
    diff_s      = Outp ^ EXP_TABLE[vec_q];
    case (state_q)
      ST_IDLE: begin
        inp_d  = 2'b00;
        busy_d = 1'b0;
        if (Start) begin
          state_d     = ST_DRIVE;
          vec_d       = 2'd0;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          err_cnt_d   = {ERR_W{1'b0}};
          fail_vec_d  = 2'd0;
          fail_mask_d = {OUT_W{1'b0}};
          tmr_load_s  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        inp_d = vec_q;
        if (tmr_zero_s) begin
          state_d = ST_SAMPLE;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      ST_SAMPLE: begin
        // only the first mismatching vector is captured in Fail_Vec/Fail_Mask
        if (diff_s != {OUT_W{1'b0}}) begin
          err_cnt_d = err_cnt_q + ERR_W'(1);
          if (err_cnt_q == {ERR_W{1'b0}}) begin
            fail_vec_d  = vec_q;
            fail_mask_d = diff_s;
          end else begin
            fail_vec_d  = fail_vec_q;
          end
        end else begin
          err_cnt_d = err_cnt_q;
        end
        if (vec_q == 2'd3) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == {ERR_W{1'b0}});
          inp_d   = 2'b00;
        end else begin
          state_d    = ST_DRIVE;
          vec_d      = vec_q + 2'd1;
          inp_d      = vec_q + 2'd1;
          tmr_load_s = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        inp_d   = 2'b00;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        inp_d   = 2'b00;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      vec_q       <= 2'd0;
      inp_q       <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= {ERR_W{1'b0}};
      fail_vec_q  <= 2'd0;
      fail_mask_q <= {OUT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      inp_q       <= inp_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      fail_vec_q  <= fail_vec_d;
      fail_mask_q <= fail_mask_d;
    end
  end

  assign Inp_1     = inp_q[0];
  assign Inp_2     = inp_q[1];
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Pass      = pass_q;
  assign Err_Cnt   = err_cnt_q;
  assign Fail_Vec  = fail_vec_q;
  assign Fail_Mask = fail_mask_q;

endmodule

// File: doc/logic_unit_sweep_ctrl.md
Name: logic_unit_sweep_ctrl

Overview:
Self-test sequencer for the two-input, five-output logic unit (NOT, AND, OR, NAND, XOR).
- Drives the unit's two inputs through all four combinations, holding each for a programmable settle time.
- Samples the five outputs and compares them against the expected truth table.
- Reports pass/fail, error count and first-failure details.
- Sits between a start source (button/host) and the logic unit instance.

Parameters:
HOLD_CYCLES, 4, number of DRIVE cycles each input vector is held before sampling; legal range 1..255.
TMR_W, 8, width of the hold timer.
ERR_W, 3, width of the error counter; holds 0..4.

Ports:
Clk  in  1  system clock, rising edge.
Rst  in  1  asynchronous, active-high reset.
Start  in  1  level sampled each edge; accepted only in IDLE.
Inp_1  out  1  drives the unit's Inp_1; this is vector bit 0.
Inp_2  out  1  drives the unit's Inp_2; this is vector bit 1.
Outp  in  5  unit outputs: [0]=NOT Inp_1, [1]=AND, [2]=OR, [3]=NAND, [4]=XOR.
Busy  out  1  high from the cycle after Start is accepted until FINISH completes.
Done  out  1  one-cycle pulse at sweep end.
Pass  out  1  1 if the completed sweep had zero mismatches; held until the next accepted Start.
Err_Cnt  out  ERR_W  number of vectors with any mismatch.
Fail_Vec  out  2  vector index of the first mismatch.
Fail_Mask  out  5  Outp XOR expected at the first mismatch.

Behaviour:
- Reset (async, Rst=1):
  - State = IDLE; vec = 0; timer = 0.
  - All outputs = 0.
  - A reset mid-sweep aborts immediately: no Done, and Pass stays 0.
- All outputs are registered.
- Expected Outp per vec {Inp_2, Inp_1}:
  - 00 -> 5'b01001
  - 01 -> 5'b11100
  - 10 -> 5'b11101
  - 11 -> 5'b00110
- FSM states: IDLE, DRIVE, SAMPLE, FINISH.
- IDLE:
  - Inp_1 = Inp_2 = 0.
  - Start=1 -> DRIVE, with vec=0 and timer=HOLD_CYCLES-1.
  - Same edge also clears Err_Cnt, Pass, Fail_Vec and Fail_Mask.
- DRIVE:
  - Inp_2/Inp_1 = vec.
  - timer decrements each cycle.
  - timer==0 -> SAMPLE.
- SAMPLE (one cycle; inputs still held):
  - Compare Outp against the expected value for vec.
  - Mismatch -> Err_Cnt+1.
  - If this is the first mismatch (Err_Cnt==0), latch Fail_Vec=vec and Fail_Mask=Outp^expected.
  - vec==3 -> FINISH; else vec+1, timer reload, -> DRIVE.
- FINISH (one cycle):
  - Done=1.
  - Pass = (Err_Cnt==0), computed after the final SAMPLE's update.
  - Inputs return to 00.
  - -> IDLE.
- Latency: Start accepted at edge k -> Busy=1 from k+1 -> Done high during cycle k+1+4*(HOLD_CYCLES+1). For HOLD_CYCLES=4, that is 21 cycles after acceptance.
- Start while Busy or in FINISH: ignored, no queuing.
- Start held high continuously: a new sweep is accepted on the first IDLE cycle after FINISH. Back-to-back sweeps are separated by exactly one IDLE cycle.
- Err_Cnt never exceeds 4, so no saturation logic is needed.
- Outp may contain X during reset; compare only in SAMPLE.

Decomposition:
- Shared package logic_unit_pkg:
  - state encoding (IDLE=0, DRIVE=1, SAMPLE=2, FINISH=3)
  - output bit-index constants (OUT_NOT..OUT_XOR)
  - 4-entry expected-output table
- One sub-module, sweep_hold_timer: loadable down-counter with load, enable and zero flag, TMR_W wide. The FSM, comparator and result registers stay in the top.

Test Plan:
- Reset mid-sweep: assert Rst during DRIVE of vec 2 -> all outputs 0 the same cycle; no Done afterward; the next Start runs a full sweep from vec 0.
- Golden unit (correct logic unit connected), HOLD_CYCLES=4, pulse Start at edge k:
  - Inp_2/Inp_1 sequence 00,01,10,11, each held 5 cycles.
  - Done at k+21.
  - Pass=1, Err_Cnt=0, Fail_Vec=0, Fail_Mask=0.
- Faulty XOR (bit 4 stuck at 0):
  - Mismatches at vec 1 and vec 2.
  - Err_Cnt=2, Pass=0, Fail_Vec=1, Fail_Mask=5'b10000.
- Faulty NOT (bit 0 inverted): all 4 vectors fail -> Err_Cnt=4, Fail_Vec=0, Fail_Mask=5'b00001, Pass=0.
- Start re-pulsed during DRIVE of vec 1: ignored; sweep completes with the original timing and Done fires once.
- Start held high for 50 cycles with HOLD_CYCLES=1: Done pulses at k+9 and k+19; results cleared at k+10.
